adder_operand_loader: RTL and testbench
=======================================

Name: adder_operand_loader

Overview:
Upstream feeder for the Adder_test_SS core. It collects operand bytes arriving one at a time on the 8-bit dedicated input pins and assembles two WIDTH-bit operands, A then B. It presents the pair to the adder with a valid/ready handshake. This lets the 8-pin tile interface drive adders wider than 8 bits.

Parameters:
WIDTH, 16, operand width in bits; must be a multiple of 8 and at least 8.
NB, WIDTH/8, bytes per operand; derived, not overridable.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, asynchronous assert, active-low
ena  input  1  tile enable; gates byte acceptance only
clear  input  1  synchronous abort; discards partial operands
byte_in  input  8  operand byte (from ui_in)
byte_valid  input  1  byte_in holds a valid byte
byte_ready  output  1  loader can accept a byte this cycle
op_a  output  WIDTH  operand A to the adder
op_b  output  WIDTH  operand B to the adder
op_valid  output  1  op_a/op_b complete and stable
op_ready  input  1  adder accepts the pair
byte_cnt  output  $clog2(2*NB+1)  bytes accepted in the current pair, 0..2*NB

Behaviour:
- Reset: one clock; asynchronous, active-low.
  - Asserting rst_n low immediately gives state=LOAD_A, op_a=0, op_b=0, op_valid=0, byte_cnt=0.
  - Reset mid-load or mid-issue discards everything.
- States:
  - LOAD_A: accepting bytes 0..NB-1.
  - LOAD_B: accepting bytes NB..2*NB-1.
  - ISSUE: holding the pair for the adder.
- byte_ready = ena & ~clear & (state is LOAD_A or LOAD_B). It is combinational from state.
  - While rst_n is low it equals ena.
- Byte accept occurs when byte_valid & byte_ready are both high at a rising edge.
- Byte order is little-endian. Byte k of an operand lands in bits [8k+7:8k].
  - Implement as a right-shift: new byte enters at the MSB, the register shifts right by 8.
  - After NB accepts, byte 0 sits in bits [7:0].
- byte_cnt increments by 1 on each accept.
- State transitions:
  - LOAD_A -> LOAD_B on accept with byte_cnt == NB-1.
  - LOAD_B -> ISSUE on accept with byte_cnt == 2*NB-1.
  - ISSUE -> LOAD_A when op_valid & op_ready; byte_cnt returns to 0.
- op_valid is registered. It is high exactly while in ISSUE, and rises the cycle after the final byte is accepted.
- While op_valid is high:
  - op_a and op_b are stable and byte_ready is low. There is no byte loss; upstream stalls.
  - op_valid does not drop until op_ready is seen, regardless of ena.
- Back-to-back operation: a handshake in cycle t allows a byte accept in cycle t+1.
  - Minimum period is 2*NB+1 cycles per pair.
- op_a and op_b hold their last values after the handshake. They are overwritten progressively during the next load.
- clear (synchronous, highest priority below reset):
  - Next state LOAD_A, byte_cnt=0, op_valid=0, op_a=op_b=0.
  - A byte presented in the same cycle is not accepted, because byte_ready is already low.
  - If clear and op_ready are both high while op_valid is high, the handshake counts as completed for the adder. The loader still goes to LOAD_A.
- ena low: no byte accepts and state is frozen in the LOAD states. ISSUE handshakes still complete.
- byte_valid while byte_ready is low: ignored, no side effects.
- No arithmetic is performed here. The adder owns carry/width rules.

Decomposition:
- Shared package adder_pkg holds:
  - the state enum {LOAD_A, LOAD_B, ISSUE};
  - the default WIDTH constant (16), also used by the adder core;
  - a function returning the byte_cnt width.
- Optional sub-module: operand_shift_reg, a WIDTH-bit right-shifting byte register with load-enable and sync clear. It is instantiated twice, once for A and once for B.
- All other logic stays in one module.

Test Plan:
- Basic load (WIDTH=16, ena=1, op_ready=0): bytes 0x34, 0x12, 0x78, 0x56 in consecutive cycles.
  - op_valid rises the cycle after the 4th byte, with op_a=0x1234, op_b=0x5678, byte_cnt=4, byte_ready=0.
- Backpressure: hold op_ready=0 for 5 cycles while byte_valid=1 with 0xAA.
  - op_valid, op_a and op_b stay constant and no byte is accepted.
  - Raise op_ready for 1 cycle: op_valid falls next cycle, byte_cnt=0, and 0xAA is then accepted as byte 0 of A.
- Clear mid-load: accept 0x11, 0x22, 0x33, then pulse clear.
  - byte_cnt=0, op_a=0, op_b=0.
  - Then 0x01, 0x00, 0x02, 0x00 gives op_a=0x0001, op_b=0x0002.
- ena gating: drop ena for 3 cycles with byte_valid=1 after 2 bytes accepted.
  - byte_ready=0 and byte_cnt stays at 2.
  - Restoring ena resumes loading; the final operands are correct.
- Async reset in ISSUE: pulse rst_n low mid-cycle.
  - op_valid, op_a, op_b and byte_cnt go to 0 immediately, without waiting for a clock edge.
  - The next pair loads correctly.
- Back-to-back (op_ready tied 1): stream 8 bytes continuously.
  - Two pairs issue; the 5th byte is accepted the cycle after the first handshake.
  - Total time is 10 cycles.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the adder tile: loader state encoding, default operand
// width and the width helper for the loader's byte counter.
package adder_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    ISSUE  = 2'd2
  } load_state_t;

  // Counter must reach 2*NB, so it needs room for 2*NB+1 distinct values.
  function automatic int cnt_width(input int width);
    return $clog2(2 * (width / 8) + 1);
  endfunction

endpackage

// File: rtl/operand_shift_reg.sv
// WIDTH-bit byte register that shifts right by one byte per load; the new byte
// enters at the top so the first byte loaded ends up in the least significant byte.
module operand_shift_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic [7:0]       byte_in,
  output logic [WIDTH-1:0] data
);

  logic [WIDTH-1:0] shifted;

  generate
    if (WIDTH == 8) begin : g_single
      assign shifted = byte_in;
    end else begin : g_multi
      assign shifted = {byte_in, data[WIDTH-1:8]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
    end else if (clear) begin
      data <= '0;
    end else if (load) begin
      data <= shifted;
    end
  end

endmodule

// File: rtl/adder_operand_loader.sv
// Assembles two WIDTH-bit operands from a byte-wide input stream (A first, then B,
// little-endian) and offers the pair to the adder with a valid/ready handshake.
module adder_operand_loader
  import adder_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int NB    = WIDTH / 8,
  localparam int CW    = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             clear,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             op_valid,
  input  logic             op_ready,
  output logic [CW-1:0]    byte_cnt
);

  localparam logic [CW-1:0] LAST_A = CW'(NB - 1);
  localparam logic [CW-1:0] LAST_B = CW'(2 * NB - 1);

  load_state_t   state_q, state_d;
  logic [CW-1:0] cnt_d;
  logic          valid_d;
  logic          load_a, load_b;
  logic          accept;

  assign byte_ready = ena & ~clear & (state_q != ISSUE);
  assign accept     = byte_valid & byte_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= LOAD_A;
      byte_cnt <= '0;
      op_valid <= 1'b0;
    end else begin
      state_q  <= state_d;
      byte_cnt <= cnt_d;
      op_valid <= valid_d;
    end
  end

  // Clear overrides everything; otherwise bytes advance the load states and the
  // handshake in ISSUE returns to LOAD_A independently of ena.
  always_comb begin
    state_d = state_q;
    cnt_d   = byte_cnt;
    valid_d = op_valid;
    load_a  = 1'b0;
    load_b  = 1'b0;
    if (clear) begin
      state_d = LOAD_A;
      cnt_d   = '0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        LOAD_A: begin
          if (accept) begin
            load_a = 1'b1;
            cnt_d  = byte_cnt + CW'(1);
            if (byte_cnt == LAST_A) state_d = LOAD_B;
          end
        end
        LOAD_B: begin
          if (accept) begin
            load_b = 1'b1;
            cnt_d  = byte_cnt + CW'(1);
            if (byte_cnt == LAST_B) begin
              state_d = ISSUE;
              valid_d = 1'b1;
            end
          end
        end
        ISSUE: begin
          if (op_valid && op_ready) begin
            state_d = LOAD_A;
            cnt_d   = '0;
            valid_d = 1'b0;
          end
        end
        default: begin
          state_d = LOAD_A;
          cnt_d   = '0;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  operand_shift_reg #(.WIDTH(WIDTH)) u_reg_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .load    (load_a),
    .byte_in (byte_in),
    .data    (op_a)
  );

  operand_shift_reg #(.WIDTH(WIDTH)) u_reg_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .load    (load_b),
    .byte_in (byte_in),
    .data    (op_b)
  );

endmodule

// File: tb/tb_adder_operand_loader.sv
// Directed bench for adder_operand_loader (WIDTH=16): a vector table for the
// single-cycle behaviour plus sequences for async reset and back-to-back streaming.
module tb_adder_operand_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic        clear;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        op_valid;
  logic        op_ready;
  logic [2:0]  byte_cnt;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic        ena;
    logic        clear;
    logic        bv;
    logic [7:0]  bin;
    logic        ord;
    logic        exp_br;
    logic        exp_ov;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
    logic [2:0]  exp_cnt;
  } vec_t;

  vec_t vecs[$];

  adder_operand_loader #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .clear      (clear),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .byte_cnt   (byte_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic e, input logic c, input logic bv, input logic [7:0] bin,
                     input logic ord, input logic br, input logic ov,
                     input logic [15:0] a, input logic [15:0] b, input logic [2:0] cnt);
    vec_t v;
    v.ena = e; v.clear = c; v.bv = bv; v.bin = bin; v.ord = ord;
    v.exp_br = br; v.exp_ov = ov; v.exp_a = a; v.exp_b = b; v.exp_cnt = cnt;
    vecs.push_back(v);
  endtask

  // Called at a negedge: drive, check byte_ready, clock once, check registered outputs.
  task automatic apply_stimulus(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    ena = v.ena; clear = v.clear; byte_valid = v.bv; byte_in = v.bin; op_ready = v.ord;
    #1;
    check_output({tag, ".byte_ready"}, 32'(byte_ready), 32'(v.exp_br));
    @(posedge clk);
    @(negedge clk);
    check_output({tag, ".op_valid"}, 32'(op_valid), 32'(v.exp_ov));
    check_output({tag, ".op_a"}, 32'(op_a), 32'(v.exp_a));
    check_output({tag, ".op_b"}, 32'(op_b), 32'(v.exp_b));
    check_output({tag, ".byte_cnt"}, 32'(byte_cnt), 32'(v.exp_cnt));
  endtask

  task automatic feed(input logic [7:0] b);
    ena = 1'b1; clear = 1'b0; op_ready = 1'b0; byte_valid = 1'b1; byte_in = b;
    @(posedge clk);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  initial begin
    int hs_cnt;
    int hs_cycle[2];
    logic [15:0] hs_a[2];
    logic [15:0] hs_b[2];
    int accept_cycle[8];
    int nbytes;
    logic br_s, ov_s;
    logic [15:0] a_s, b_s;

    rst_n = 1'b0; ena = 1'b1; clear = 1'b0; byte_in = 8'h00; byte_valid = 1'b0; op_ready = 1'b0;
    #12;
    check_output("rst.op_valid", 32'(op_valid), 32'd0);
    check_output("rst.op_a", 32'(op_a), 32'd0);
    check_output("rst.op_b", 32'(op_b), 32'd0);
    check_output("rst.byte_cnt", 32'(byte_cnt), 32'd0);
    check_output("rst.byte_ready_ena1", 32'(byte_ready), 32'd1);
    ena = 1'b0;
    #1;
    check_output("rst.byte_ready_ena0", 32'(byte_ready), 32'd0);
    ena = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    // Basic load
    add(1,0,1,8'h34,0, 1,0,16'h3400,16'h0000,3'd1);
    add(1,0,1,8'h12,0, 1,0,16'h1234,16'h0000,3'd2);
    add(1,0,1,8'h78,0, 1,0,16'h1234,16'h7800,3'd3);
    add(1,0,1,8'h56,0, 1,1,16'h1234,16'h5678,3'd4);
    // Backpressure with a byte waiting
    for (int i = 0; i < 5; i++) add(1,0,1,8'hAA,0, 0,1,16'h1234,16'h5678,3'd4);
    add(1,0,1,8'hAA,1, 0,0,16'h1234,16'h5678,3'd0);
    add(1,0,1,8'hAA,0, 1,0,16'hAA12,16'h5678,3'd1);
    // Clear mid-load
    add(1,1,1,8'h55,0, 0,0,16'h0000,16'h0000,3'd0);
    add(1,0,1,8'h11,0, 1,0,16'h1100,16'h0000,3'd1);
    add(1,0,1,8'h22,0, 1,0,16'h2211,16'h0000,3'd2);
    add(1,0,1,8'h33,0, 1,0,16'h2211,16'h3300,3'd3);
    add(1,1,1,8'h44,0, 0,0,16'h0000,16'h0000,3'd0);
    add(1,0,1,8'h01,0, 1,0,16'h0100,16'h0000,3'd1);
    add(1,0,1,8'h00,0, 1,0,16'h0001,16'h0000,3'd2);
    add(1,0,1,8'h02,0, 1,0,16'h0001,16'h0200,3'd3);
    add(1,0,1,8'h00,0, 1,1,16'h0001,16'h0002,3'd4);
    add(1,0,0,8'h00,1, 0,0,16'h0001,16'h0002,3'd0);
    // ena gating after two bytes
    add(1,0,1,8'hAB,0, 1,0,16'hAB00,16'h0002,3'd1);
    add(1,0,1,8'hCD,0, 1,0,16'hCDAB,16'h0002,3'd2);
    for (int i = 0; i < 3; i++) add(0,0,1,8'hEE,0, 0,0,16'hCDAB,16'h0002,3'd2);
    add(1,0,1,8'hEF,0, 1,0,16'hCDAB,16'hEF00,3'd3);
    add(1,0,1,8'h01,0, 1,1,16'hCDAB,16'h01EF,3'd4);
    // Handshake completes with ena low
    add(0,0,0,8'h00,1, 0,0,16'hCDAB,16'h01EF,3'd0);
    // Clear together with op_ready while issuing
    add(1,0,1,8'h10,0, 1,0,16'h10CD,16'h01EF,3'd1);
    add(1,0,1,8'h20,0, 1,0,16'h2010,16'h01EF,3'd2);
    add(1,0,1,8'h30,0, 1,0,16'h2010,16'h3001,3'd3);
    add(1,0,1,8'h40,0, 1,1,16'h2010,16'h4030,3'd4);
    add(1,1,1,8'h99,1, 0,0,16'h0000,16'h0000,3'd0);

    for (int i = 0; i < vecs.size(); i++) apply_stimulus(vecs[i], i);

    // Async reset while issuing
    feed(8'h0F); feed(8'h0E); feed(8'h0D); feed(8'h0C);
    check_output("ar.pre_valid", 32'(op_valid), 32'd1);
    check_output("ar.pre_a", 32'(op_a), 32'h0E0F);
    #2 rst_n = 1'b0;
    #1;
    check_output("ar.op_valid", 32'(op_valid), 32'd0);
    check_output("ar.op_a", 32'(op_a), 32'd0);
    check_output("ar.op_b", 32'(op_b), 32'd0);
    check_output("ar.byte_cnt", 32'(byte_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    feed(8'hA1); feed(8'hB2); feed(8'hC3); feed(8'hD4);
    check_output("ar.next_valid", 32'(op_valid), 32'd1);
    check_output("ar.next_a", 32'(op_a), 32'hB2A1);
    check_output("ar.next_b", 32'(op_b), 32'hD4C3);
    check_output("ar.next_cnt", 32'(byte_cnt), 32'd4);
    op_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op_ready = 1'b0;
    check_output("ar.hs_valid", 32'(op_valid), 32'd0);

    // Back-to-back streaming with op_ready tied high
    hs_cnt = 0; nbytes = 0;
    ena = 1'b1; clear = 1'b0; op_ready = 1'b1;
    for (int c = 1; c <= 30 && hs_cnt < 2; c++) begin
      byte_valid = (nbytes < 8);
      byte_in = 8'(nbytes + 1);
      #1;
      br_s = byte_ready; ov_s = op_valid; a_s = op_a; b_s = op_b;
      @(posedge clk);
      if (br_s && nbytes < 8) begin
        accept_cycle[nbytes] = c;
        nbytes++;
      end
      if (ov_s) begin
        hs_cycle[hs_cnt] = c; hs_a[hs_cnt] = a_s; hs_b[hs_cnt] = b_s;
        hs_cnt++;
      end
      @(negedge clk);
    end
    byte_valid = 1'b0; op_ready = 1'b0;
    check_output("b2b.handshakes", 32'(hs_cnt), 32'd2);
    check_output("b2b.bytes", 32'(nbytes), 32'd8);
    if (hs_cnt == 2 && nbytes == 8) begin
      check_output("b2b.hs1_cycle", 32'(hs_cycle[0]), 32'd5);
      check_output("b2b.byte5_cycle", 32'(accept_cycle[4]), 32'd6);
      check_output("b2b.hs2_cycle", 32'(hs_cycle[1]), 32'd10);
      check_output("b2b.a1", 32'(hs_a[0]), 32'h0201);
      check_output("b2b.b1", 32'(hs_b[0]), 32'h0403);
      check_output("b2b.a2", 32'(hs_a[1]), 32'h0605);
      check_output("b2b.b2", 32'(hs_b[1]), 32'h0807);
    end
    check_output("b2b.end_cnt", 32'(byte_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
